commit_trace_buffer: RTL and testbench

- Synthesizable retire-event monitor for the pipelined 16-bit CPU; the on-chip successor to the behavioural SIMLOG/trace bench logic.
- Samples the writeback-stage register write, data-memory access and halt each cycle, and maintains cycle and instruction counters.
- Time-stamps each event into a parametrised FIFO that a debug port or bench drains over a valid/ready handshake.
- Adds halt and timeout state tracking plus overflow accounting.

---
 rtl/commit_trace_buffer.sv | 180 ++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: retire-event monitor for the pipelined 16-bit CPU.
// Samples writeback register writes, data-memory accesses and halt while in RUN.
// Each event is time-stamped into a FIFO that is drained over a valid/ready port.
// The monitor also keeps cycle, instruction and drop counters.
// Optional build macro TRACE_FILTER_EN adds an ev_mask input that filters pushes.
// Halt always pushes, whatever the mask says.
module commit_trace_buffer #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               reg_we,
  input  logic [REG_W-1:0]   reg_id,
  input  logic [DATA_W-1:0]  reg_data,
  input  logic               mem_re,
  input  logic               mem_we,
  input  logic [DATA_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               halt,
`ifdef TRACE_FILTER_EN
  input  logic [3:0]         ev_mask,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_kind,
  output logic [REG_W-1:0]   out_reg_id,
  output logic [DATA_W-1:0]  out_reg_data,
  output logic [DATA_W-1:0]  out_mem_addr,
  output logic [DATA_W-1:0]  out_mem_data,
  output logic [CYCLE_W-1:0] out_cycle,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [CYCLE_W-1:0] inst_count,
  output logic [7:0]         drop_count,
  output logic               overflow,
  output logic [1:0]         state_o,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CYCLE_W-1:0] TIMEOUT_C = CYCLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_HALTED  = 2'b10,
    S_TIMEOUT = 2'b11
  } state_e;

  typedef struct packed {
    logic [3:0]         kind;
    logic [REG_W-1:0]   reg_id;
    logic [DATA_W-1:0]  reg_data;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data;
    logic [CYCLE_W-1:0] cycle;
  } entry_t;

  state_e state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, inst_q, cycle_inc;
  logic [7:0]         drop_q;
  logic               ovf_q;
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  entry_t             mem_q [DEPTH];

  logic [3:0] kind;
  logic       is_run, capture, empty, full, pop, push_ok, drop, timeout_hit;
  entry_t     new_entry, head;

  assign kind        = {halt, mem_we, mem_re, reg_we};
  assign is_run      = (state_q == S_RUN);
  assign cycle_inc   = cycle_q + CYCLE_W'(1);
  assign timeout_hit = (cycle_inc == TIMEOUT_C);

`ifdef TRACE_FILTER_EN
  assign capture = is_run & (halt | (|(kind & ev_mask)));
`else
  assign capture = is_run & (|kind);
`endif

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  always_comb begin
    new_entry          = '0;
    new_entry.kind     = kind;
    new_entry.reg_id   = reg_id;
    new_entry.reg_data = reg_data;
    new_entry.mem_addr = mem_addr;
    new_entry.mem_data = mem_we ? mem_wdata : (mem_re ? mem_rdata : '0);
    new_entry.cycle    = cycle_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; halt wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_RUN;
      S_RUN: begin
        if (halt)             state_d = S_HALTED;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  // Output decode from state.
  always_comb begin
    state_o = state_q;
    done    = ((state_q == S_HALTED) || (state_q == S_TIMEOUT)) && empty;
  end

  // Cycle and instruction counters advance only in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= '0;
      inst_q  <= '0;
    end else if (is_run) begin
      cycle_q <= cycle_inc;
      if (halt | reg_we | mem_we) inst_q <= inst_q + CYCLE_W'(1);
    end
  end

  // Drop accounting: saturating counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  // FIFO pointers; reset discards any queued entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage write; when full with a pop, the slot being freed is reused.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

  assign head         = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid    = ~empty;
  assign out_kind     = head.kind;
  assign out_reg_id   = head.reg_id;
  assign out_reg_data = head.reg_data;
  assign out_mem_addr = head.mem_addr;
  assign out_mem_data = head.mem_data;
  assign out_cycle    = head.cycle;
  assign cycle_count  = cycle_q;
  assign inst_count   = inst_q;
  assign drop_count   = drop_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer (DEPTH=16, TIMEOUT=50).
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        reg_we = 1'b0, mem_re = 1'b0, mem_we = 1'b0, halt = 1'b0;
  logic [3:0]  reg_id = '0;
  logic [15:0] reg_data = '0, mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [3:0]  out_kind, out_reg_id;
  logic [15:0] out_reg_data, out_mem_addr, out_mem_data;
  logic [31:0] out_cycle, cycle_count, inst_count;
  logic [7:0]  drop_count;
  logic        overflow, done;
  logic [1:0]  state_o;

  commit_trace_buffer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm),
    .reg_we(reg_we), .reg_id(reg_id), .reg_data(reg_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
`ifdef TRACE_FILTER_EN
    .ev_mask(4'hF),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_reg_id(out_reg_id), .out_reg_data(out_reg_data),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_cycle(out_cycle), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .state_o(state_o), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [3:0]  rid;
    logic [15:0] rd;
    logic [15:0] ad;
    logic [15:0] md;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          failures  = 0;
  logic [1:0]  m_state;
  logic [31:0] m_cyc, m_inst;
  logic [7:0]  m_drop;
  logic        m_ovf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    m_state = 2'b00; m_cyc = '0; m_inst = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  // One cycle of stimulus: checks/pops the head if out_ready, updates the model,
  // clocks the DUT and checks the status outputs afterwards.
  task automatic step(input logic [3:0] k, input logic [3:0] rid, input logic [15:0] rd,
                      input logic [15:0] ad, input logic [15:0] wd, input logic [15:0] rdd);
    exp_t e;
    exp_t n;
    logic pop;
    int   occ;
    logic m_done;
    reg_we = k[0]; mem_re = k[1]; mem_we = k[2]; halt = k[3];
    reg_id = rid; reg_data = rd; mem_addr = ad; mem_wdata = wd; mem_rdata = rdd;
    occ = sb.size();
    tests_run++;
    if (out_valid !== (occ != 0)) begin
      failures++;
      $display("FAIL valid: got %b want %b", out_valid, occ != 0);
    end
    pop = out_ready && (occ != 0);
    if (pop) begin
      e = sb.pop_front();
      tests_run++;
      if ({out_kind, out_reg_id, out_reg_data, out_mem_addr, out_mem_data, out_cycle} !==
          {e.kind, e.rid, e.rd, e.ad, e.md, e.cyc}) begin
        failures++;
        $display("FAIL entry: got k=%b id=%h rd=%h ad=%h md=%h cyc=%0d want k=%b id=%h rd=%h ad=%h md=%h cyc=%0d",
                 out_kind, out_reg_id, out_reg_data, out_mem_addr, out_mem_data, out_cycle,
                 e.kind, e.rid, e.rd, e.ad, e.md, e.cyc);
      end
    end
    if (m_state == 2'b01) begin
      if (k != 4'b0000) begin
        if (occ < DEPTH || pop) begin
          n.kind = k; n.rid = rid; n.rd = rd; n.ad = ad;
          n.md = k[2] ? wd : (k[1] ? rdd : 16'h0000);
          n.cyc = m_cyc;
          sb.push_back(n);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      if (k[3] | k[2] | k[0]) m_inst = m_inst + 1;
      m_cyc = m_cyc + 1;
      if (k[3]) m_state = 2'b10;
      else if (m_cyc == TMO) m_state = 2'b11;
    end else if (m_state == 2'b00 && arm) begin
      m_state = 2'b01;
    end
    tick();
    reg_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0; halt = 1'b0;
    m_done = m_state[1] && (sb.size() == 0);
    tests_run++;
    if ({state_o, cycle_count, inst_count, drop_count, overflow, done} !==
        {m_state, m_cyc, m_inst, m_drop, m_ovf, m_done}) begin
      failures++;
      $display("FAIL status: got st=%b cyc=%0d inst=%0d drop=%0d ovf=%b done=%b want st=%b cyc=%0d inst=%0d drop=%0d ovf=%b done=%b",
               state_o, cycle_count, inst_count, drop_count, overflow, done,
               m_state, m_cyc, m_inst, m_drop, m_ovf, m_done);
    end
  endtask

  task automatic idle_step();
    step(4'b0000, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic arm_run();
    arm = 1'b1;
    idle_step();
    arm = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle_step();
    tests_run++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: valid=%b left=%0d want valid=0 left=0", out_valid, sb.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    tests_run++;
    if ({out_valid, state_o, cycle_count, inst_count, drop_count, overflow, done} !== '0) begin
      failures++;
      $display("FAIL %s: valid=%b st=%b cyc=%0d inst=%0d drop=%0d ovf=%b done=%b want all 0",
               tag, out_valid, state_o, cycle_count, inst_count, drop_count, overflow, done);
    end
    tests_run++;
    if ({out_kind, out_reg_id, out_reg_data, out_mem_addr, out_mem_data, out_cycle} !== '0) begin
      failures++;
      $display("FAIL %s_data: got k=%b id=%h rd=%h ad=%h md=%h cyc=%0d want 0",
               tag, out_kind, out_reg_id, out_reg_data, out_mem_addr, out_mem_data, out_cycle);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_cleared("reset");
  endtask

  task automatic test_idle_ignore();
    do_reset();
    step(4'b0101, 4'h2, 16'h1111, 16'h0002, 16'h2222, 16'h0);
    step(4'b1000, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    arm = 1'b1;
    step(4'b0001, 4'h7, 16'h7777, 16'h0, 16'h0, 16'h0);
    arm = 1'b0;
    idle_step();
    drain();
  endtask

  task automatic test_reg_write();
    do_reset();
    arm_run();
    step(4'b0001, 4'h3, 16'h1234, 16'h0, 16'h0, 16'h0);
    tests_run++;
    if (inst_count !== 32'd1) begin
      failures++;
      $display("FAIL reg_inst: got %0d want 1", inst_count);
    end
    drain();
  endtask

  task automatic test_mem_access();
    do_reset();
    arm_run();
    step(4'b0100, 4'h0, 16'h0, 16'h0040, 16'hBEEF, 16'h0000);
    step(4'b0010, 4'h0, 16'h0, 16'h0040, 16'h0000, 16'hBEEF);
    step(4'b0011, 4'h5, 16'h5A5A, 16'h0041, 16'h0000, 16'hCAFE);
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    arm_run();
    for (int i = 0; i < 20; i++) step(4'b0001, 4'(i), 16'(16'h0100 + i), 16'h0, 16'h0, 16'h0);
    tests_run++;
    if (drop_count !== 8'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf: got drop=%0d ovf=%b want drop=4 ovf=1", drop_count, overflow);
    end
    out_ready = 1'b1;
    step(4'b0001, 4'hE, 16'hABCD, 16'h0, 16'h0, 16'h0);
    out_ready = 1'b0;
    step(4'b0001, 4'hF, 16'hDEAD, 16'h0, 16'h0, 16'h0);
    drain();
  endtask

  task automatic test_halt();
    do_reset();
    arm_run();
    for (int i = 0; i < 7; i++) idle_step();
    step(4'b1000, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tests_run++;
    if (state_o !== 2'b10) begin
      failures++;
      $display("FAIL halt_state: got %b want 10", state_o);
    end
    arm = 1'b1;
    step(4'b0001, 4'h1, 16'h9999, 16'h0, 16'h0, 16'h0);
    arm = 1'b0;
    drain();
    idle_step();
  endtask

  task automatic test_halt_at_timeout();
    do_reset();
    arm_run();
    for (int i = 0; i < TMO - 1; i++) idle_step();
    step(4'b1001, 4'h4, 16'h4444, 16'h0, 16'h0, 16'h0);
    drain();
  endtask

  task automatic test_timeout();
    do_reset();
    arm_run();
    for (int i = 0; i < TMO; i++) begin
      if (i == 3) step(4'b0110, 4'h0, 16'h0, 16'h0080, 16'h1357, 16'h2468);
      else idle_step();
    end
    tests_run++;
    if (state_o !== 2'b11 || cycle_count !== 32'(TMO)) begin
      failures++;
      $display("FAIL timeout: got st=%b cyc=%0d want st=11 cyc=%0d", state_o, cycle_count, TMO);
    end
    step(4'b0001, 4'h2, 16'h2222, 16'h0, 16'h0, 16'h0);
    drain();
    idle_step();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    arm_run();
    for (int i = 0; i < 5; i++) step(4'b0001, 4'(i), 16'(i * 3), 16'h0, 16'h0, 16'h0);
    do_reset();
    check_cleared("midrun_reset");
    idle_step();
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_reg_write();
    test_mem_access();
    test_overflow();
    test_halt();
    test_halt_at_timeout();
    test_timeout();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
